// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction / data) arbiter in front of one memory port.
// A grant is taken in IDLE. In-window accesses go to BUSY, which holds mem_valid until
// mem_ready is seen or the wait counter expires. Out-of-window accesses skip BUSY and
// go straight to an error response. RESP pulses the owner's ready for one cycle.
// All outputs are registered.
//
// Optional feature: define MEM_ARBITER_ROUND_ROBIN_EN to make ties alternate between
// the two ports. Without it, the data port always wins a tie.
//
// Ports:
//   clock, reset             : rising-edge clock, asynchronous active-high reset
//   imem_valid/addr          : instruction request
//   imem_rdata/ready/error   : instruction response (ready is a 1-cycle pulse)
//   dmem_valid/addr/wdata/wstrb : data request (wstrb == 0 means read)
//   dmem_rdata/ready/error   : data response (ready is a 1-cycle pulse)
//   mem_valid/instr/addr/wdata/wstrb : downstream request
//   mem_rdata/ready          : downstream response
module mem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] TOP_ADDR  = 32'h9000_0000,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  output logic        imem_error,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_error,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        grant_any, grant_imem, in_window;
  logic [31:0] gnt_addr;
  logic        mem_valid_nxt, mem_instr_nxt;
  logic [31:0] mem_addr_nxt, mem_wdata_nxt;
  logic [3:0]  mem_wstrb_nxt;
  logic        rsp_fire, rsp_imem, rsp_err;
  logic [31:0] rsp_data;

  // Arbitration: evaluated every cycle, only acted on in IDLE.
  assign grant_any = imem_valid | dmem_valid;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_imem;  // 1 = instruction port won the previous grant

  assign grant_imem = imem_valid & (~dmem_valid | ~last_imem);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      last_imem <= 1'b0;
    else if (state == IDLE && grant_any)
      last_imem <= grant_imem;
  end
`else
  assign grant_imem = imem_valid & ~dmem_valid;
`endif

  assign gnt_addr  = grant_imem ? imem_addr : dmem_addr;
  assign in_window = (gnt_addr >= BASE_ADDR) && (gnt_addr < TOP_ADDR);

  // State register and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      mem_valid  <= 1'b0;
      mem_instr  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
      imem_ready <= 1'b0;
      imem_error <= 1'b0;
      imem_rdata <= 32'd0;
      dmem_ready <= 1'b0;
      dmem_error <= 1'b0;
      dmem_rdata <= 32'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mem_valid  <= mem_valid_nxt;
      mem_instr  <= mem_instr_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      mem_wstrb  <= mem_wstrb_nxt;
      imem_ready <= rsp_fire & rsp_imem;
      imem_error <= rsp_fire & rsp_imem & rsp_err;
      dmem_ready <= rsp_fire & ~rsp_imem;
      dmem_error <= rsp_fire & ~rsp_imem & rsp_err;
      // Read data only moves on a response; it holds its value otherwise.
      if (rsp_fire & rsp_imem)
        imem_rdata <= rsp_data;
      if (rsp_fire & ~rsp_imem)
        dmem_rdata <= rsp_data;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant_any) state_nxt = in_window ? BUSY : RESP;
      BUSY: if (mem_ready || cnt == CNT_LAST) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    cnt_nxt       = cnt;
    mem_valid_nxt = mem_valid;
    mem_instr_nxt = mem_instr;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_wstrb_nxt = mem_wstrb;
    rsp_fire      = 1'b0;
    rsp_imem      = mem_instr;  // owner of the access in flight
    rsp_err       = 1'b0;
    rsp_data      = 32'd0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          cnt_nxt       = 16'd0;
          mem_instr_nxt = grant_imem;
          mem_addr_nxt  = gnt_addr;
          mem_wdata_nxt = grant_imem ? 32'd0 : dmem_wdata;
          mem_wstrb_nxt = grant_imem ? 4'd0 : dmem_wstrb;
          if (in_window) begin
            mem_valid_nxt = 1'b1;
          end else begin
            // Out-of-window: answer with an error without touching memory.
            rsp_fire = 1'b1;
            rsp_imem = grant_imem;
            rsp_err  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_valid_nxt = 1'b0;
          rsp_fire      = 1'b1;
          rsp_data      = mem_rdata;
        end else if (cnt == CNT_LAST) begin
          mem_valid_nxt = 1'b0;
          rsp_fire      = 1'b1;
          rsp_err       = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: ;
    endcase
  end
endmodule
